// File: rtl/nibble_mayor_ctrl_if.sv
// Nibble source stream: valid/ready handshake carrying one 4-bit value per transfer.
interface nibble_mayor_ctrl_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/nibble_mayor_ctrl.sv
// Burst max-finder that time-multiplexes one external 2-input nibble-max unit.
// Reports the burst maximum and the 0-based index of its first occurrence.
module nibble_mayor_ctrl #(
  parameter int unsigned LEN_W   = 5,
  parameter int unsigned CMP_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  nibble_mayor_ctrl_if.slave sif,
  output logic [3:0]       cmp_a,
  output logic [3:0]       cmp_b,
  input  logic [3:0]       cmp_mayor,
  output logic             out_valid,
  output logic [3:0]       out_mayor,
  output logic [LEN_W-1:0] out_idx
);

  localparam int unsigned WAIT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_NEXT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cand_idx;
  logic [LEN_W-1:0]  acc_idx;
  logic [3:0]        acc;
  logic [WAIT_W-1:0] wcnt;
  logic              in_ready_q;
  logic              xfer_c;
  logic [LEN_W-1:0]  cnt_inc_c;

  // Handshake and element-count helpers.
  assign sif.in_ready = in_ready_q;
  assign xfer_c       = sif.in_valid & in_ready_q;
  assign cnt_inc_c    = cnt + LEN_W'(1);

  // Sequencer: capture burst, issue compares, wait out comparator latency, report.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      len_q      <= '0;
      cnt        <= '0;
      cand_idx   <= '0;
      acc_idx    <= '0;
      acc        <= '0;
      wcnt       <= '0;
      in_ready_q <= 1'b0;
      busy       <= 1'b0;
      cmp_a      <= '0;
      cmp_b      <= '0;
      out_valid  <= 1'b0;
      out_mayor  <= '0;
      out_idx    <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && (len != '0)) begin
            len_q      <= len;
            busy       <= 1'b1;
            in_ready_q <= 1'b1;
            state      <= S_FIRST;
          end
        end
        S_FIRST: begin
          if (xfer_c) begin
            acc     <= sif.in_data;
            acc_idx <= '0;
            cnt     <= LEN_W'(1);
            if (len_q == LEN_W'(1)) begin
              in_ready_q <= 1'b0;
              state      <= S_DONE;
            end else begin
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (xfer_c) begin
            cmp_a      <= acc;
            cmp_b      <= sif.in_data;
            cand_idx   <= cnt;
            wcnt       <= WAIT_W'(CMP_LAT);
            in_ready_q <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Only a strictly greater candidate replaces acc, so ties keep the earliest index.
          if (wcnt == '0) begin
            if (cmp_mayor != acc) begin
              acc     <= cmp_mayor;
              acc_idx <= cand_idx;
            end
            cnt <= cnt_inc_c;
            if (cnt_inc_c == len_q) begin
              state <= S_DONE;
            end else begin
              in_ready_q <= 1'b1;
              state      <= S_NEXT;
            end
          end else begin
            wcnt <= wcnt - WAIT_W'(1);
          end
        end
        S_DONE: begin
          out_valid <= 1'b1;
          out_mayor <= acc;
          out_idx   <= acc_idx;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_mayor_ctrl.sv
// Self-checking bench for nibble_mayor_ctrl with a registered max model on cmp_*.
module tb_nibble_mayor_ctrl;
  localparam int unsigned LEN_W   = 5;
  localparam int unsigned CMP_LAT = 1;

  typedef struct {
    logic [4:0]        len;
    logic [15:0][3:0]  d;
    logic [3:0]        m;
    logic [4:0]        idx;
    bit                rnd;
    bit                mid;
    bit                gap;
  } vec_t;

  typedef struct packed {
    logic [3:0] m;
    logic [4:0] idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [4:0] len = '0;
  logic       busy;
  logic [3:0] cmp_a, cmp_b, cmp_mayor;
  logic       out_valid;
  logic [3:0] out_mayor;
  logic [4:0] out_idx;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   exp_pulses = 0;
  logic prev_ov = 1'b0;
  exp_t sb[$];
  vec_t vt[5];

  nibble_mayor_ctrl_if sif();

  nibble_mayor_ctrl #(.LEN_W(LEN_W), .CMP_LAT(CMP_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .sif       (sif),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_mayor (cmp_mayor),
    .out_valid (out_valid),
    .out_mayor (out_mayor),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One-stage registered max unit.
  always @(posedge clk) cmp_mayor <= (cmp_a > cmp_b) ? cmp_a : cmp_b;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result monitor: pops the scoreboard on every out_valid pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (out_valid === 1'b1) begin
      pulses++;
      chk("ov_single", int'(prev_ov), 0);
      chk("ov_busy", int'(busy), 0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ov_unexpected: got out_valid=1 want no pulse (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("out_mayor", int'(out_mayor), int'(e.m));
        chk("out_idx", int'(out_idx), int'(e.idx));
      end
    end
    prev_ov = out_valid;
  end

  task automatic check_zero(input string pfx);
    chk({pfx, "_busy"}, int'(busy), 0);
    chk({pfx, "_in_ready"}, int'(sif.in_ready), 0);
    chk({pfx, "_cmp_a"}, int'(cmp_a), 0);
    chk({pfx, "_cmp_b"}, int'(cmp_b), 0);
    chk({pfx, "_out_valid"}, int'(out_valid), 0);
    chk({pfx, "_out_mayor"}, int'(out_mayor), 0);
    chk({pfx, "_out_idx"}, int'(out_idx), 0);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 1, 0);
  endtask

  // Offer one nibble until it is accepted; returns cycles seen with in_ready low.
  task automatic xfer(input logic [3:0] d, input bit rnd, output int lows, output bit ok);
    bit x;
    lows = 0;
    ok = 1'b0;
    sif.in_data = d;
    for (int k = 0; k < 200; k++) begin
      sif.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (!sif.in_ready) lows++;
      x = sif.in_valid && sif.in_ready;
      @(posedge clk);
      #1;
      if (x) begin
        ok = 1'b1;
        break;
      end
    end
    sif.in_valid = 1'b0;
    if (!ok) chk("xfer_timeout", 1, 0);
  endtask

  task automatic wait_ov(input string name, input int exp_lat);
    int k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(name, k, exp_lat);
  endtask

  task automatic send_burst(input vec_t v);
    logic [3:0] macc = '0;
    int lows;
    int tprev = 0;
    bit ok;
    wait_idle();
    start = 1'b1;
    len = v.len;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{m: v.m, idx: v.idx});
    exp_pulses++;
    for (int i = 0; i < int'(v.len); i++) begin
      if (v.mid && i == 2) begin
        start = 1'b1;
        len = 5'd2;
      end
      xfer(v.d[i], v.rnd, lows, ok);
      start = 1'b0;
      if (!ok) return;
      if (i >= 1) begin
        chk("cmp_a", int'(cmp_a), int'(macc));
        chk("cmp_b", int'(cmp_b), int'(v.d[i]));
      end
      if (v.gap && i >= 2) begin
        chk("xfer_gap", cyc - tprev, 3);
        chk("ready_low", lows, 2);
      end
      tprev = cyc;
      if (i == 0 || v.d[i] > macc) macc = v.d[i];
    end
    wait_ov("latency", (v.len == 5'd1) ? 1 : int'(CMP_LAT) + 2);
  endtask

  initial begin
    int   lows;
    bit   ok;
    vec_t hv;

    vt[0] = '{len: 5'd1,  d: 64'h7,                m: 4'h7, idx: 5'd0,  rnd: 1'b0, mid: 1'b0, gap: 1'b0};
    vt[1] = '{len: 5'd4,  d: 64'h9293,             m: 4'h9, idx: 5'd1,  rnd: 1'b0, mid: 1'b0, gap: 1'b0};
    vt[2] = '{len: 5'd16, d: 64'hFEDCBA9876543210, m: 4'hF, idx: 5'd15, rnd: 1'b0, mid: 1'b0, gap: 1'b1};
    vt[3] = '{len: 5'd5,  d: 64'hFFFFF,            m: 4'hF, idx: 5'd0,  rnd: 1'b1, mid: 1'b1, gap: 1'b0};
    vt[4] = '{len: 5'd5,  d: 64'h0CC3A,            m: 4'hC, idx: 5'd2,  rnd: 1'b1, mid: 1'b0, gap: 1'b0};

    sif.in_valid = 1'b0;
    sif.in_data  = '0;

    // Reset held two cycles, then released.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_zero("post_rst");

    for (int i = 0; i < 5; i++) send_burst(vt[i]);

    // Reset in the middle of a len=6 burst aborts it silently.
    wait_idle();
    start = 1'b1;
    len = 5'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    xfer(4'h2, 1'b0, lows, ok);
    xfer(4'h5, 1'b0, lows, ok);
    xfer(4'h3, 1'b0, lows, ok);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_zero("abort");
    repeat (10) @(posedge clk);
    #1;
    chk("abort_idle", int'(busy), 0);
    hv = '{len: 5'd2, d: 64'h41, m: 4'h4, idx: 5'd1, rnd: 1'b0, mid: 1'b0, gap: 1'b0};
    send_burst(hv);

    // start with len=0 is ignored.
    wait_idle();
    start = 1'b1;
    len = 5'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      chk("len0_busy", int'(busy), 0);
      chk("len0_ready", int'(sif.in_ready), 0);
      @(posedge clk);
      #1;
    end

    // start on the DONE cycle is ignored; start in the following IDLE cycle is taken.
    wait_idle();
    start = 1'b1;
    len = 5'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{m: 4'hE, idx: 5'd0});
    exp_pulses++;
    xfer(4'hE, 1'b0, lows, ok);
    chk("done_ov_low", int'(out_valid), 0);
    start = 1'b1;
    len = 5'd2;
    @(posedge clk);
    #1;
    chk("done_start_ign", int'(busy), 0);
    chk("done_ov_high", int'(out_valid), 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("idle_start_acc", int'(busy), 1);
    chk("idle_start_rdy", int'(sif.in_ready), 1);
    sb.push_back('{m: 4'h6, idx: 5'd1});
    exp_pulses++;
    xfer(4'h3, 1'b0, lows, ok);
    xfer(4'h6, 1'b0, lows, ok);
    chk("b2b_cmp_a", int'(cmp_a), 3);
    chk("b2b_cmp_b", int'(cmp_b), 6);
    wait_ov("b2b_latency", int'(CMP_LAT) + 2);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("pulses", pulses, exp_pulses);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
